line_fetch_ctrl: RTL and testbench

LINE_FETCH_CTRL -- requirements
Module: line_fetch_ctrl

---
 rtl/psram_pkg.sv | 31 +++
 rtl/wait_timer.sv | 26 ++
 rtl/line_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_line_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared constants and FSM encoding for the PSRAM line-fetch path.
package psram_pkg;

  localparam int PSRAM_AW             = 23;
  localparam int DATA_W               = 16;
  localparam int LINE_IDX_W           = 9;
  localparam int BRAM_AW              = LINE_IDX_W + 1;
  localparam int DEF_BURST_LEN        = 128;
  localparam int DEF_BURSTS_PER_LINE  = 4;
  localparam int DEF_CYC_PER_WORD     = 2;
  localparam int DEF_TIMEOUT          = 255;

  // Line bases are aligned to 128 words regardless of burst length.
  localparam logic [PSRAM_AW-1:0] LINE_BASE_MASK = 23'h7FFF80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BEGIN,
    ST_WAIT_DATA,
    ST_STREAM,
    ST_NEXT,
    ST_ERR
  } fetch_state_t;

  // Counter width that stays legal (>= 1 bit) for a count of one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Modulo counter with clear and enable; flags when the count equals TERMINAL.
module wait_timer #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic at_terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == WIDTH'(MODULUS - 1)) ? '0 : count_reg + 1'b1;
    end
  end

  assign at_terminal = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/line_fetch_ctrl.sv
// Fetches one 512-word line from PSRAM as a series of burst reads and
// streams the words into one half of a ping-pong BRAM.
module line_fetch_ctrl
  import psram_pkg::*;
#(
  parameter int BURST_LEN       = DEF_BURST_LEN,
  parameter int BURSTS_PER_LINE = DEF_BURSTS_PER_LINE,
  parameter int CYC_PER_WORD    = DEF_CYC_PER_WORD,
  parameter int TIMEOUT         = DEF_TIMEOUT
) (
  input  logic                  app_clk,
  input  logic                  clr,
  input  logic                  line_req,
  input  logic [PSRAM_AW-1:0]   line_base,
  input  logic                  buf_sel,
  output logic                  busy,
  output logic                  line_done,
  output logic                  fetch_err,
  input  logic                  app_ctrlr_good,
  input  logic                  app_op_begun,
  input  logic                  app_data_ok,
  input  logic [DATA_W-1:0]     app_data_out,
  output logic [PSRAM_AW-1:0]   app_addr,
  output logic                  app_rd,
  output logic                  app_burst_op,
  output logic [BRAM_AW-1:0]    bram_addr,
  output logic [DATA_W-1:0]     bram_din,
  output logic                  bram_we
);

  localparam int BURST_W = cnt_width(BURSTS_PER_LINE);
  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int DIV_W   = cnt_width(CYC_PER_WORD);

  fetch_state_t              state_reg, state_next;
  logic [PSRAM_AW-1:0]       base_reg, base_next;
  logic                      buf_reg, buf_next;
  logic [BURST_W-1:0]        burst_reg, burst_next;
  logic [LINE_IDX_W-1:0]     idx_reg, idx_next;
  logic [BEAT_W-1:0]         beat_reg, beat_next;

  logic waiting;
  logic tmo_clear;
  logic tmo_expired;
  logic word_strobe;
  logic stream_end;

  always_ff @(posedge app_clk) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      base_reg  <= '0;
      buf_reg   <= 1'b0;
      burst_reg <= '0;
      idx_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      buf_reg   <= buf_next;
      burst_reg <= burst_next;
      idx_reg   <= idx_next;
      beat_reg  <= beat_next;
    end
  end

  // The wait counter restarts on every entry into a wait state.
  assign waiting   = (state_reg == ST_WAIT_BEGIN) || (state_reg == ST_WAIT_DATA);
  assign tmo_clear = !waiting || (state_next != state_reg);

  wait_timer #(
    .WIDTH    (TMO_W),
    .MODULUS  (TIMEOUT),
    .TERMINAL (TIMEOUT - 1)
  ) u_tmo_timer (
    .clk         (app_clk),
    .srst        (clr),
    .clear       (tmo_clear),
    .enable      (waiting),
    .at_terminal (tmo_expired)
  );

  // Phase 0 of the word divider is the capture slot; it starts at 0 on STREAM entry.
  wait_timer #(
    .WIDTH    (DIV_W),
    .MODULUS  (CYC_PER_WORD),
    .TERMINAL (0)
  ) u_word_div (
    .clk         (app_clk),
    .srst        (clr),
    .clear       (state_reg != ST_STREAM),
    .enable      (1'b1),
    .at_terminal (word_strobe)
  );

  // CYC_PER_WORD is 1 or 2: at one cycle per word the last capture closes the
  // burst, at two the filler cycle after the last capture does.
  always_comb begin
    if (CYC_PER_WORD == 1) begin
      stream_end = word_strobe && (beat_reg == BEAT_W'(BURST_LEN - 1));
    end else begin
      stream_end = !word_strobe && (beat_reg == BEAT_W'(BURST_LEN));
    end
  end

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    buf_next     = buf_reg;
    burst_next   = burst_reg;
    idx_next     = idx_reg;
    beat_next    = beat_reg;
    busy         = (state_reg != ST_IDLE);
    line_done    = 1'b0;
    fetch_err    = 1'b0;
    app_rd       = 1'b0;
    app_burst_op = 1'b0;
    bram_we      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (line_req && app_ctrlr_good) begin
          base_next  = line_base & LINE_BASE_MASK;
          buf_next   = buf_sel;
          burst_next = '0;
          idx_next   = '0;
          beat_next  = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        app_rd     = 1'b1;
        state_next = app_op_begun ? ST_WAIT_DATA : ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        app_rd = 1'b1;
        if (app_op_begun) begin
          state_next = ST_WAIT_DATA;
        end else if (tmo_expired) begin
          state_next = ST_ERR;
        end
      end
      ST_WAIT_DATA: begin
        if (app_data_ok) begin
          state_next = ST_STREAM;
        end else if (tmo_expired) begin
          state_next = ST_ERR;
        end
      end
      ST_STREAM: begin
        app_burst_op = 1'b1;
        if (word_strobe) begin
          bram_we   = 1'b1;
          idx_next  = idx_reg + 1'b1;
          beat_next = beat_reg + 1'b1;
        end
        if (stream_end) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (burst_reg == BURST_W'(BURSTS_PER_LINE - 1)) begin
          line_done  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          burst_next = burst_reg + 1'b1;
          beat_next  = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ERR: begin
        fetch_err = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign app_addr  = base_reg + (PSRAM_AW'(burst_reg) * PSRAM_AW'(BURST_LEN));
  assign bram_addr = {buf_reg, idx_reg};
  assign bram_din  = bram_we ? app_data_out : '0;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench: unit 0 runs at two cycles per word, unit 1 at one; a small
// controller model answers each burst read with its own address as data.
module tb_line_fetch_ctrl;

  localparam int NU = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        line_req    [NU];
  logic [22:0] line_base   [NU];
  logic        buf_sel     [NU];
  logic        ctrlr_good  [NU];
  logic        withhold    [NU];
  logic        op_begun    [NU];
  logic        data_ok     [NU];
  logic [15:0] data_out    [NU];
  logic [22:0] app_addr    [NU];
  logic        app_rd      [NU];
  logic        burst_op    [NU];
  logic [9:0]  bram_addr   [NU];
  logic [15:0] bram_din    [NU];
  logic        bram_we     [NU];
  logic        busy        [NU];
  logic        line_done   [NU];
  logic        fetch_err   [NU];

  generate
    for (genvar gi = 0; gi < NU; gi++) begin : g_unit
      line_fetch_ctrl #(
        .BURST_LEN       (128),
        .BURSTS_PER_LINE (4),
        .CYC_PER_WORD    ((gi == 0) ? 2 : 1),
        .TIMEOUT         (255)
      ) u_dut (
        .app_clk        (clk),
        .clr            (clr),
        .line_req       (line_req[gi]),
        .line_base      (line_base[gi]),
        .buf_sel        (buf_sel[gi]),
        .busy           (busy[gi]),
        .line_done      (line_done[gi]),
        .fetch_err      (fetch_err[gi]),
        .app_ctrlr_good (ctrlr_good[gi]),
        .app_op_begun   (op_begun[gi]),
        .app_data_ok    (data_ok[gi]),
        .app_data_out   (data_out[gi]),
        .app_addr       (app_addr[gi]),
        .app_rd         (app_rd[gi]),
        .app_burst_op   (burst_op[gi]),
        .bram_addr      (bram_addr[gi]),
        .bram_din       (bram_din[gi]),
        .bram_we        (bram_we[gi])
      );
    end
  endgenerate

  // Controller model and write monitor state.
  logic [22:0] maddr    [NU] = '{default: '0};
  logic        got      [NU] = '{default: 1'b0};
  int          scnt     [NU] = '{default: 0};
  int          line_idx [NU] = '{default: 0};
  int          bad_cnt  [NU] = '{default: 0};
  int          adj_cnt  [NU] = '{default: 0};
  int          done_cnt [NU] = '{default: 0};
  int          iss_cnt  [NU] = '{default: 0};
  int          req_cyc  [NU] = '{default: 0};
  int          done_cyc [NU] = '{default: 0};
  logic        prev_we  [NU] = '{default: 1'b0};
  logic [22:0] iss_addr [NU][4] = '{default: '{default: '0}};
  logic [22:0] exp_base [NU];
  logic        exp_buf  [NU];
  int          cyc = 0;

  int checks   = 0;
  int failures = 0;

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      op_begun[u] = app_rd[u] && !withhold[u];
      data_ok[u]  = got[u];
      data_out[u] = 16'(maddr[u] + 23'(scnt[u] / ((u == 0) ? 2 : 1)));
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < NU; u++) begin
      if (app_rd[u] && op_begun[u]) begin
        maddr[u] <= app_addr[u];
        got[u]   <= 1'b1;
        scnt[u]  <= 0;
        if (iss_cnt[u] < 4) iss_addr[u][iss_cnt[u]] <= app_addr[u];
        iss_cnt[u] <= iss_cnt[u] + 1;
      end else if (burst_op[u]) begin
        got[u]  <= 1'b0;
        scnt[u] <= scnt[u] + 1;
      end
      if (line_req[u] && !busy[u] && ctrlr_good[u]) begin
        line_idx[u] <= 0;
        iss_cnt[u]  <= 0;
        adj_cnt[u]  <= 0;
        prev_we[u]  <= 1'b0;
        req_cyc[u]  <= cyc;
      end else begin
        if (bram_we[u]) begin
          line_idx[u] <= line_idx[u] + 1;
          if (bram_addr[u] != {exp_buf[u], 9'(line_idx[u])} ||
              bram_din[u] != 16'(exp_base[u] + 23'(line_idx[u])))
            bad_cnt[u] <= bad_cnt[u] + 1;
          if (prev_we[u]) adj_cnt[u] <= adj_cnt[u] + 1;
        end
        prev_we[u] <= bram_we[u];
      end
      if (line_done[u]) begin
        done_cnt[u] <= done_cnt[u] + 1;
        done_cyc[u] <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic start_line(input int u, input logic [22:0] base, input logic bsel,
                            input logic [22:0] ebase);
    @(negedge clk);
    exp_base[u]  = ebase;
    exp_buf[u]   = bsel;
    line_base[u] = base;
    buf_sel[u]   = bsel;
    line_req[u]  = 1'b1;
    @(negedge clk);
    line_req[u]  = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int budget);
    int n = 0;
    while (busy[u] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(busy[u]), 32'd0);
  endtask

  int b0, d0, n;

  initial begin
    clr = 1'b1;
    for (int u = 0; u < NU; u++) begin
      line_req[u] = 1'b0; line_base[u] = '0; buf_sel[u] = 1'b0;
      ctrlr_good[u] = 1'b1; withhold[u] = 1'b0;
      exp_base[u] = '0; exp_buf[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy[0]),      0);
    check("rst_fetch_err", 32'(fetch_err[0]), 0);
    check("rst_line_done", 32'(line_done[0]), 0);
    check("rst_app_rd",    32'(app_rd[0]),    0);
    check("rst_burst_op",  32'(burst_op[0]),  0);
    check("rst_bram_we",   32'(bram_we[0]),   0);
    check("rst_app_addr",  32'(app_addr[0]),  0);
    check("rst_bram_addr", 32'(bram_addr[0]), 0);
    check("rst_bram_din",  32'(bram_din[0]),  0);
    clr = 1'b0;

    // Basic line into the upper buffer half.
    b0 = bad_cnt[0]; d0 = done_cnt[0];
    start_line(0, 23'h000100, 1'b1, 23'h000100);
    wait_idle(0, 2000);
    check("t1_writes",  32'(line_idx[0]), 512);
    check("t1_bad",     32'(bad_cnt[0] - b0), 0);
    check("t1_done",    32'(done_cnt[0] - d0), 1);
    check("t1_latency", 32'(done_cyc[0] - req_cyc[0]), 1036);
    $display("line u=0 base=000100 buf=1 writes=%0d done=%0d", line_idx[0], done_cnt[0] - d0);

    // Unaligned base: low seven bits dropped.
    b0 = bad_cnt[0];
    start_line(0, 23'h00017F, 1'b0, 23'h000100);
    wait_idle(0, 2000);
    check("t2_issues", 32'(iss_cnt[0]), 4);
    check("t2_addr0",  32'(iss_addr[0][0]), 32'h000100);
    check("t2_addr1",  32'(iss_addr[0][1]), 32'h000180);
    check("t2_addr2",  32'(iss_addr[0][2]), 32'h000200);
    check("t2_addr3",  32'(iss_addr[0][3]), 32'h000280);
    check("t2_writes", 32'(line_idx[0]), 512);
    check("t2_bad",    32'(bad_cnt[0] - b0), 0);
    $display("line u=0 base=00017F buf=0 writes=%0d issues=%0d", line_idx[0], iss_cnt[0]);

    // Second request mid-fetch must be ignored.
    b0 = bad_cnt[0]; d0 = done_cnt[0];
    start_line(0, 23'h000400, 1'b0, 23'h000400);
    repeat (300) @(negedge clk);
    line_base[0] = 23'h000000; buf_sel[0] = 1'b1; line_req[0] = 1'b1;
    @(negedge clk);
    line_req[0] = 1'b0;
    wait_idle(0, 2000);
    check("t3_writes", 32'(line_idx[0]), 512);
    check("t3_bad",    32'(bad_cnt[0] - b0), 0);
    check("t3_done",   32'(done_cnt[0] - d0), 1);
    check("t3_addr0",  32'(iss_addr[0][0]), 32'h000400);
    repeat (3) @(negedge clk);
    check("t3_stays_idle", 32'(busy[0]), 0);
    $display("line u=0 base=000400 buf=0 writes=%0d done=%0d (extra req ignored)", line_idx[0], done_cnt[0] - d0);

    // Request while the controller is not ready.
    ctrlr_good[0] = 1'b0;
    start_line(0, 23'h000800, 1'b0, 23'h000800);
    repeat (3) @(negedge clk);
    check("t4_busy",   32'(busy[0]),   0);
    check("t4_app_rd", 32'(app_rd[0]), 0);
    ctrlr_good[0] = 1'b1;
    $display("line u=0 ctrlr_good=0 busy=%0d", busy[0]);

    // op_begun withheld: timeout to ERR.
    d0 = done_cnt[0];
    withhold[0] = 1'b1;
    start_line(0, 23'h000000, 1'b0, 23'h000000);
    repeat (300) @(negedge clk);
    check("t5_fetch_err", 32'(fetch_err[0]), 1);
    check("t5_app_rd",    32'(app_rd[0]),    0);
    check("t5_burst_op",  32'(burst_op[0]),  0);
    check("t5_busy",      32'(busy[0]),      1);
    check("t5_no_done",   32'(done_cnt[0] - d0), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    withhold[0] = 1'b0;
    check("t5_err_cleared", 32'(fetch_err[0]), 0);
    $display("line u=0 withheld op_begun fetch_err seen, cleared by clr");

    // clr after 37 words of burst 2, then a clean line.
    start_line(0, 23'h000000, 1'b0, 23'h000000);
    n = 0;
    while (line_idx[0] != 293 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_word", 32'(line_idx[0]), 293);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("t6_burst_op", 32'(burst_op[0]), 0);
    check("t6_bram_we",  32'(bram_we[0]),  0);
    check("t6_busy",     32'(busy[0]),     0);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_more_writes", 32'(line_idx[0]), 293);
    b0 = bad_cnt[0]; d0 = done_cnt[0];
    start_line(0, 23'h000800, 1'b1, 23'h000800);
    wait_idle(0, 2000);
    check("t6_writes", 32'(line_idx[0]), 512);
    check("t6_bad",    32'(bad_cnt[0] - b0), 0);
    check("t6_done",   32'(done_cnt[0] - d0), 1);
    $display("line u=0 base=000800 buf=1 after clr writes=%0d done=%0d", line_idx[0], done_cnt[0] - d0);

    // One cycle per word at the top of the address space.
    b0 = bad_cnt[1]; d0 = done_cnt[1];
    start_line(1, 23'h7FFE00, 1'b0, 23'h7FFE00);
    wait_idle(1, 1000);
    check("t7_writes",   32'(line_idx[1]), 512);
    check("t7_bad",      32'(bad_cnt[1] - b0), 0);
    check("t7_adjacent", 32'(adj_cnt[1]), 508);
    check("t7_addr0",    32'(iss_addr[1][0]), 32'h7FFE00);
    check("t7_addr3",    32'(iss_addr[1][3]), 32'h7FFF80);
    check("t7_done",     32'(done_cnt[1] - d0), 1);
    check("t7_latency",  32'(done_cyc[1] - req_cyc[1]), 524);
    check("t7_err",      32'(fetch_err[1]), 0);
    $display("line u=1 base=7FFE00 buf=0 writes=%0d adjacent=%0d", line_idx[1], adj_cnt[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
